// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline-stage registers: control-bit
// positions within the control vector and the default field widths.
package pipe_pkg;

  localparam int PC_W = 32;
  localparam int RW_W = 5;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_JAL      = 2;
  localparam int CTRL_JALR     = 3;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_BRANCH   = 5;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic MIPS pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WR) with a
// valid/ready handshake, a one-entry skid buffer, flush squash and ctrl gating.
module pipe_stage_reg #(
  parameter int DATA_W    = 64,
  parameter int CTRL_W    = 8,
  parameter int RW_W      = pipe_pkg::RW_W,
  parameter int GATE_CTRL = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [pipe_pkg::PC_W-1:0] in_pc,
  input  logic [pipe_pkg::PC_W-1:0] in_pc_plus4,
  input  logic [pipe_pkg::PC_W-1:0] in_inst,
  input  logic [RW_W-1:0]           in_rw,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [pipe_pkg::PC_W-1:0] out_pc,
  output logic [pipe_pkg::PC_W-1:0] out_pc_plus4,
  output logic [pipe_pkg::PC_W-1:0] out_inst,
  output logic [RW_W-1:0]           out_rw,
  output logic [DATA_W-1:0]         out_data,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [CNT_W-1:0]          squash_cnt
);
  import pipe_pkg::*;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W - 1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic              main_valid, skid_valid;
  logic [PC_W-1:0]   main_pc, main_pc_plus4, main_inst;
  logic [RW_W-1:0]   main_rw;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [PC_W-1:0]   skid_pc, skid_pc_plus4, skid_inst;
  logic [RW_W-1:0]   skid_rw;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic       accept, main_drain;
  logic [1:0] squash_inc;

  // in_ready depends only on registered skid state, never on out_ready
  assign in_ready   = rst_n & ~skid_valid;
  assign accept     = in_valid & in_ready;
  assign main_drain = ~main_valid | out_ready;
  assign squash_inc = {1'b0, main_valid} + {1'b0, skid_valid} + {1'b0, accept};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid    <= 1'b0;
      skid_valid    <= 1'b0;
      squash_cnt    <= '0;
      main_pc       <= '0;
      main_pc_plus4 <= '0;
      main_inst     <= '0;
      main_rw       <= '0;
      main_data     <= '0;
      main_ctrl     <= '0;
      skid_pc       <= '0;
      skid_pc_plus4 <= '0;
      skid_inst     <= '0;
      skid_rw       <= '0;
      skid_data     <= '0;
      skid_ctrl     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      squash_cnt <= sat_add(squash_cnt, squash_inc);
    end else if (main_drain) begin
      if (skid_valid) begin
        main_valid    <= 1'b1;
        main_pc       <= skid_pc;
        main_pc_plus4 <= skid_pc_plus4;
        main_inst     <= skid_inst;
        main_rw       <= skid_rw;
        main_data     <= skid_data;
        main_ctrl     <= skid_ctrl;
        skid_valid    <= accept;
        if (accept) begin
          skid_pc       <= in_pc;
          skid_pc_plus4 <= in_pc_plus4;
          skid_inst     <= in_inst;
          skid_rw       <= in_rw;
          skid_data     <= in_data;
          skid_ctrl     <= in_ctrl;
        end
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_pc       <= in_pc;
          main_pc_plus4 <= in_pc_plus4;
          main_inst     <= in_inst;
          main_rw       <= in_rw;
          main_data     <= in_data;
          main_ctrl     <= in_ctrl;
        end
      end
    end else if (accept) begin
      // main is full and stalled: park the beat in the skid entry
      skid_valid    <= 1'b1;
      skid_pc       <= in_pc;
      skid_pc_plus4 <= in_pc_plus4;
      skid_inst     <= in_inst;
      skid_rw       <= in_rw;
      skid_data     <= in_data;
      skid_ctrl     <= in_ctrl;
    end
  end

  assign out_valid    = main_valid;
  assign out_pc       = main_pc;
  assign out_pc_plus4 = main_pc_plus4;
  assign out_inst     = main_inst;
  assign out_rw       = main_rw;
  assign out_data     = main_data;
  // a bubble must never assert RegWrite/MemWrite downstream
  assign out_ctrl     = ((GATE_CTRL != 0) && !main_valid) ? '0 : main_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random
// run checked against a queue-based model of the stage.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [4:0]  rw;
    logic [63:0] data;
    logic [7:0]  ctrl;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_pc_plus4, in_inst;
  logic [4:0]  in_rw;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_pc_plus4, out_inst;
  logic [4:0]  out_rw;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic [15:0] squash_cnt;

  logic        ng_in_ready, ng_out_valid;
  logic [31:0] ng_out_pc, ng_out_pc_plus4, ng_out_inst;
  logic [4:0]  ng_out_rw;
  logic [63:0] ng_out_data;
  logic [7:0]  ng_out_ctrl;
  logic [15:0] ng_squash_cnt;

  logic        c2_in_ready, c2_out_valid;
  logic [31:0] c2_out_pc, c2_out_pc_plus4, c2_out_inst;
  logic [4:0]  c2_out_rw;
  logic [63:0] c2_out_data;
  logic [7:0]  c2_out_ctrl;
  logic [1:0]  c2_squash_cnt;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_inst(in_inst), .in_rw(in_rw),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .out_inst(out_inst), .out_rw(out_rw), .out_data(out_data),
    .out_ctrl(out_ctrl), .squash_cnt(squash_cnt));

  pipe_stage_reg #(.GATE_CTRL(0)) dut_ng (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ng_in_ready),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_inst(in_inst), .in_rw(in_rw),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(ng_out_valid),
    .out_ready(out_ready), .out_pc(ng_out_pc), .out_pc_plus4(ng_out_pc_plus4),
    .out_inst(ng_out_inst), .out_rw(ng_out_rw), .out_data(ng_out_data),
    .out_ctrl(ng_out_ctrl), .squash_cnt(ng_squash_cnt));

  pipe_stage_reg #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_in_ready),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_inst(in_inst), .in_rw(in_rw),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(c2_out_valid),
    .out_ready(out_ready), .out_pc(c2_out_pc), .out_pc_plus4(c2_out_pc_plus4),
    .out_inst(c2_out_inst), .out_rw(c2_out_rw), .out_data(c2_out_data),
    .out_ctrl(c2_out_ctrl), .squash_cnt(c2_squash_cnt));

  // reference model: the stage holds an ordered list of at most two beats
  beat_t       mq[$];
  beat_t       hold;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  int          checks = 0;
  int          errors = 0;

  function automatic beat_t cur_beat();
    beat_t b;
    b.pc = in_pc; b.pc4 = in_pc_plus4; b.inst = in_inst;
    b.rw = in_rw; b.data = in_data; b.ctrl = in_ctrl;
    return b;
  endfunction

  task automatic drive_beat(input logic [31:0] pc, input logic [7:0] ctrl);
    in_pc = pc; in_pc_plus4 = pc + 32'd4; in_inst = $urandom;
    in_rw = 5'($urandom); in_data = {$urandom, $urandom}; in_ctrl = ctrl;
  endtask

  task automatic step();
    bit acc;
    int inc, t;
    @(posedge clk);
    acc = in_valid && rst_n && (mq.size() < 2);
    if (!rst_n) begin
      mq.delete(); m_cnt = '0; m_cnt2 = '0; hold = '0;
    end else if (flush) begin
      inc = mq.size() + int'(acc);
      t = int'(m_cnt) + inc;
      m_cnt = (t > 65535) ? 16'hffff : 16'(t);
      t = int'(m_cnt2) + inc;
      m_cnt2 = (t > 3) ? 2'd3 : 2'(t);
      mq.delete();
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) mq.push_back(cur_beat());
    end
    if (mq.size() > 0) hold = mq[0];
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; flush = 0; out_ready = 1;
    drive_beat(32'h0000_1234, 8'hff);
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++; if (squash_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", squash_cnt); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    checks++; if (ng_out_ctrl !== 8'd0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", ng_out_ctrl); end
    rst_n = 1; in_valid = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; drive_beat(32'h0040_0000 + 32'(4 * k), 8'h01);
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000 + 32'(4 * k))
        begin errors++; $display("FAIL stream_%0d got v=%0b pc=%h exp pc=%h", k, out_valid, out_pc, 32'h0040_0000 + 32'(4 * k)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %0b exp 1", k, in_ready); end
    end
    in_valid = 0; step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %0b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] b;
    b = 32'h0040_0100;
    out_ready = 1; in_valid = 1; drive_beat(b, 8'h03); step();
    out_ready = 0; drive_beat(b + 32'd4, 8'h05); step();
    checks++; if (out_pc !== b || in_ready !== 1'b0)
      begin errors++; $display("FAIL bp_fill got pc=%h rdy=%0b exp pc=%h rdy=0", out_pc, in_ready, b); end
    drive_beat(b + 32'd8, 8'h07); step(); step();
    checks++; if (out_pc !== b || out_valid !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL bp_hold got pc=%h v=%0b rdy=%0b exp pc=%h", out_pc, out_valid, in_ready, b); end
    out_ready = 1; step();
    checks++; if (out_pc !== b + 32'd4 || out_valid !== 1'b1 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_drain1 got pc=%h rdy=%0b exp pc=%h", out_pc, in_ready, b + 32'd4); end
    step();
    checks++; if (out_pc !== b + 32'd8 || out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_drain2 got pc=%h exp %h", out_pc, b + 32'd8); end
    in_valid = 0; step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end got %0b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    logic [15:0] base;
    logic [31:0] f;
    f = 32'h0040_0200;
    out_ready = 1; in_valid = 1; drive_beat(f, 8'h11); step();
    out_ready = 0; drive_beat(f + 32'd4, 8'h13); step();
    base = m_cnt;
    drive_beat(f + 32'd8, 8'h15); flush = 1; step();
    flush = 0; in_valid = 0;
    // skid full blocks the input beat, so only main and skid are squashed
    checks++; if (squash_cnt !== base + 16'd2) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", squash_cnt, base + 16'd2); end
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00)
      begin errors++; $display("FAIL flush_out got v=%0b ctrl=%h exp v=0 ctrl=00", out_valid, out_ctrl); end
    checks++; if (out_pc !== f || ng_out_ctrl !== 8'h11)
      begin errors++; $display("FAIL flush_payload got pc=%h ctrl=%h exp pc=%h ctrl=11", out_pc, ng_out_ctrl, f); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
    out_ready = 0; in_valid = 1; drive_beat(f + 32'd12, 8'h17); step();
    base = m_cnt;
    drive_beat(f + 32'd16, 8'h19); flush = 1; step();
    flush = 0; in_valid = 0;
    checks++; if (squash_cnt !== base + 16'd2) begin errors++; $display("FAIL flush_main_in got %0d exp %0d", squash_cnt, base + 16'd2); end
  endtask

  task automatic test_gating();
    out_ready = 1; in_valid = 1; drive_beat(32'h0040_0300, 8'h01); step();
    checks++; if (out_ctrl !== 8'h01 || ng_out_ctrl !== 8'h01)
      begin errors++; $display("FAIL gate_live got %h/%h exp 01/01", out_ctrl, ng_out_ctrl); end
    in_valid = 0; step();
    checks++; if (out_ctrl !== 8'h00 || out_valid !== 1'b0)
      begin errors++; $display("FAIL gate_bubble got ctrl=%h v=%0b exp 00/0", out_ctrl, out_valid); end
    checks++; if (ng_out_ctrl !== 8'h01) begin errors++; $display("FAIL nogate_bubble got %h exp 01", ng_out_ctrl); end
  endtask

  task automatic test_saturation();
    rst_n = 0; step(); rst_n = 1;
    out_ready = 1; flush = 1; in_valid = 1;
    for (int k = 1; k <= 6; k++) begin
      drive_beat(32'h0040_0400 + 32'(4 * k), 8'h21); step();
      checks++; if (c2_squash_cnt !== ((k < 3) ? 2'(k) : 2'd3))
        begin errors++; $display("FAIL sat_%0d got %0d exp %0d", k, c2_squash_cnt, (k < 3) ? k : 3); end
      checks++; if (squash_cnt !== 16'(k))
        begin errors++; $display("FAIL wide_cnt_%0d got %0d exp %0d", k, squash_cnt, k); end
    end
    flush = 0; in_valid = 0;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1; in_valid = 1; drive_beat(32'h0040_0500, 8'h31); step();
    out_ready = 0; drive_beat(32'h0040_0504, 8'h33); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b exp 0", in_ready); end
    rst_n = 0; in_valid = 0; step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL rst_stall got v=%0b rdy=%0b exp 0/0", out_valid, in_ready); end
    checks++; if (squash_cnt !== 16'd0 || c2_squash_cnt !== 2'd0)
      begin errors++; $display("FAIL rst_stall_cnt got %0d/%0d exp 0/0", squash_cnt, c2_squash_cnt); end
    rst_n = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_release got %0b exp 1", in_ready); end
    out_ready = 1; step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_empty got %0b exp 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_beat($urandom, 8'($urandom));
      #1;
      checks++; if (in_ready !== (rst_n && mq.size() < 2))
        begin errors++; $display("FAIL rnd_ready_%0d got %0b exp %0b", i, in_ready, rst_n && mq.size() < 2); end
      step();
      checks++; if (out_valid !== (mq.size() > 0))
        begin errors++; $display("FAIL rnd_valid_%0d got %0b exp %0b", i, out_valid, mq.size() > 0); end
      checks++; if ({out_pc, out_pc_plus4, out_inst, out_rw, out_data} !== {hold.pc, hold.pc4, hold.inst, hold.rw, hold.data})
        begin errors++; $display("FAIL rnd_payload_%0d got pc=%h data=%h exp pc=%h data=%h", i, out_pc, out_data, hold.pc, hold.data); end
      checks++; if (out_ctrl !== ((mq.size() > 0) ? hold.ctrl : 8'h00) || ng_out_ctrl !== hold.ctrl)
        begin errors++; $display("FAIL rnd_ctrl_%0d got %h/%h exp %h", i, out_ctrl, ng_out_ctrl, hold.ctrl); end
      checks++; if (squash_cnt !== m_cnt || c2_squash_cnt !== m_cnt2)
        begin errors++; $display("FAIL rnd_cnt_%0d got %0d/%0d exp %0d/%0d", i, squash_cnt, c2_squash_cnt, m_cnt, m_cnt2); end
    end
    rst_n = 1; flush = 0; in_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
    m_cnt = '0; m_cnt2 = '0; hold = '0;
    drive_beat(32'd0, 8'd0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_gating();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
